// File: rtl/dmem_lsu_mem.sv
// Data memory for the MEM stage: byte/half/word loads and stores with fault detection,
// req/ready handshake, registered one-cycle response and a post-reset init sequencer.
module dmem_lsu_mem #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              fault
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [WIDX_W-1:0] DEPTH_W   = WIDX_W'(DEPTH);
    localparam logic [3:0]        WAIT_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StInit, StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  init_idx_q, init_idx_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [31:0]       hold_rdata_q, hold_rdata_d;
    logic              hold_fault_q, hold_fault_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic              resp_valid_q, resp_valid_d;

    logic [31:0]       mem_q [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [31:0]       mem_wdata;

    logic [WIDX_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic [31:0]       rd_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              illegal, misalign, acc_fault;
    logic [31:0]       acc_rdata;
    logic [31:0]       st_word;

    assign word_idx = addr[ADDR_W-1:2];
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign rd_word  = mem_q[mem_idx];
    assign ld_byte  = rd_word[{addr[1:0], 3'b000} +: 8];
    assign ld_half  = addr[1] ? rd_word[31:16] : rd_word[15:0];

    // Access decode: fault classification, load extraction and store merge.
    always_comb begin
        illegal   = 1'b0;
        misalign  = 1'b0;
        acc_rdata = 32'h0;
        st_word   = rd_word;
        case (funct3)
            3'b000: begin
                acc_rdata = {{24{ld_byte[7]}}, ld_byte};
                st_word[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
            end
            3'b001: begin
                misalign  = addr[0];
                acc_rdata = {{16{ld_half[15]}}, ld_half};
                st_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            end
            3'b010: begin
                misalign  = |addr[1:0];
                acc_rdata = rd_word;
                st_word   = wdata;
            end
            3'b100: begin
                illegal   = we;
                acc_rdata = {24'h0, ld_byte};
            end
            3'b101: begin
                illegal   = we;
                misalign  = addr[0];
                acc_rdata = {16'h0, ld_half};
            end
            default: illegal = 1'b1;
        endcase
        acc_fault = illegal | misalign | (word_idx >= DEPTH_W);
        if (acc_fault || we) begin
            acc_rdata = 32'h0;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        wait_cnt_d   = wait_cnt_q;
        hold_rdata_d = hold_rdata_q;
        hold_fault_d = hold_fault_q;
        mem_we       = 1'b0;
        mem_waddr    = mem_idx;
        mem_wdata    = st_word;
        unique case (state_q)
            StInit: begin
                mem_we     = 1'b1;
                mem_waddr  = init_idx_q;
                mem_wdata  = 32'(init_idx_q);
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == LAST_IDX) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (req) begin
                    hold_rdata_d = acc_rdata;
                    hold_fault_d = acc_fault;
                    mem_we       = we & ~acc_fault;
                    wait_cnt_d   = 4'h0;
                    state_d      = (WAIT_STATES > 0) ? StWait : StResp;
                end
            end
            StWait: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'h1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StInit;
        endcase

        // Response registers load only on entry to RESP so rdata/fault stay 0 otherwise.
        resp_valid_d = (state_d == StResp);
        rdata_d      = 32'h0;
        fault_d      = 1'b0;
        if (resp_valid_d) begin
            rdata_d = (state_q == StIdle) ? acc_rdata : hold_rdata_q;
            fault_d = (state_q == StIdle) ? acc_fault : hold_fault_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StInit;
            init_idx_q   <= '0;
            wait_cnt_q   <= 4'h0;
            hold_rdata_q <= 32'h0;
            hold_fault_q <= 1'b0;
            rdata_q      <= 32'h0;
            fault_q      <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            wait_cnt_q   <= wait_cnt_d;
            hold_rdata_q <= hold_rdata_d;
            hold_fault_q <= hold_fault_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign ready      = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_dmem_lsu_mem.sv
// Directed bench: instance 0 runs with no wait states, instance 1 with three.
module tb_dmem_lsu_mem;

    typedef struct {
        string       name;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ef;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_s   [2];
    logic        req_s   [2];
    logic        we_s    [2];
    logic [2:0]  f3_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic        ready_s [2];
    logic        resp_s  [2];
    logic [31:0] rdata_s [2];
    logic        fault_s [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    vec_t vec[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_lsu_mem #(.DEPTH(64), .ADDR_W(32), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .funct3(f3_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]), .ready(ready_s[0]), .resp_valid(resp_s[0]),
        .rdata(rdata_s[0]), .fault(fault_s[0])
    );

    dmem_lsu_mem #(.DEPTH(64), .ADDR_W(32), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .funct3(f3_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]), .ready(ready_s[1]), .resp_valid(resp_s[1]),
        .rdata(rdata_s[1]), .fault(fault_s[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ef);
        vec_t v;
        v.name = n; v.w = w; v.f3 = f3; v.a = a; v.wd = wd; v.er = er; v.ef = ef;
        vec.push_back(v);
    endtask

    // Called and returns at a negedge; lat counts cycles from acceptance to resp_valid.
    task automatic access(input int d, input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                          output int lat);
        int n;
        n = 0;
        while (!ready_s[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_s[d]) begin
            lat = -1; rd = 32'hx; flt = 1'bx;
            return;
        end
        req_s[d] = 1'b1; we_s[d] = w; f3_s[d] = f3; addr_s[d] = a; wdata_s[d] = wd;
        @(posedge clk);
        @(negedge clk);
        req_s[d] = 1'b0;
        lat = 1;
        while (!resp_s[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd  = rdata_s[d];
        flt = fault_s[d];
    endtask

    task automatic count_init(input int d, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ready_s[d] && n < 200);
    endtask

    initial begin
        logic [31:0] rd;
        logic        flt;
        int          lat;
        int          n;
        int          prev;
        int          acc;

        add("lw_3c",     1'b0, 3'b010, 32'h3C,  32'h0,        32'h0000000F, 1'b0);
        add("lw_last",   1'b0, 3'b010, 32'hFC,  32'h0,        32'h0000003F, 1'b0);
        add("sw_10",     1'b1, 3'b010, 32'h10,  32'h11223344, 32'h0,        1'b0);
        add("lb_11",     1'b0, 3'b000, 32'h11,  32'h0,        32'h00000033, 1'b0);
        add("lbu_13",    1'b0, 3'b100, 32'h13,  32'h0,        32'h00000011, 1'b0);
        add("lh_12",     1'b0, 3'b001, 32'h12,  32'h0,        32'h00001122, 1'b0);
        add("lw_10",     1'b0, 3'b010, 32'h10,  32'h0,        32'h11223344, 1'b0);
        add("sb_14",     1'b1, 3'b000, 32'h14,  32'hAAAAAA80, 32'h0,        1'b0);
        add("lb_14",     1'b0, 3'b000, 32'h14,  32'h0,        32'hFFFFFF80, 1'b0);
        add("lbu_14",    1'b0, 3'b100, 32'h14,  32'h0,        32'h00000080, 1'b0);
        add("lw_14",     1'b0, 3'b010, 32'h14,  32'h0,        32'h00000080, 1'b0);
        add("sh_1a",     1'b1, 3'b001, 32'h1A,  32'h12348001, 32'h0,        1'b0);
        add("lh_1a",     1'b0, 3'b001, 32'h1A,  32'h0,        32'hFFFF8001, 1'b0);
        add("lhu_1a",    1'b0, 3'b101, 32'h1A,  32'h0,        32'h00008001, 1'b0);
        add("lw_18",     1'b0, 3'b010, 32'h18,  32'h0,        32'h80010006, 1'b0);
        add("sh_21_mis", 1'b1, 3'b001, 32'h21,  32'h0000FFFF, 32'h0,        1'b1);
        add("lw_20",     1'b0, 3'b010, 32'h20,  32'h0,        32'h00000008, 1'b0);
        add("lw_102",    1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b1);
        add("lw_100_oor",1'b0, 3'b010, 32'h100, 32'h0,        32'h0,        1'b1);
        add("f3_011",    1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        1'b1);
        add("st_f3_100", 1'b1, 3'b100, 32'h24,  32'h000000FF, 32'h0,        1'b1);
        add("lw_24",     1'b0, 3'b010, 32'h24,  32'h0,        32'h00000009, 1'b0);
        add("lh_13_mis", 1'b0, 3'b001, 32'h13,  32'h0,        32'h0,        1'b1);
        add("sw_100_oor",1'b1, 3'b010, 32'h100, 32'h00000055, 32'h0,        1'b1);
        add("lw_0",      1'b0, 3'b010, 32'h0,   32'h0,        32'h00000000, 1'b0);

        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; req_s[d] = 1'b0; we_s[d] = 1'b0; f3_s[d] = 3'b000;
            addr_s[d] = 32'h0; wdata_s[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(ready_s[d]), 32'h0);
            check("rst_resp",  32'(resp_s[d]),  32'h0);
            check("rst_rdata", rdata_s[d],      32'h0);
            check("rst_fault", 32'(fault_s[d]), 32'h0);
        end
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        count_init(0, n);
        check("init_cycles", 32'(n), 32'd64);
        check("init_ready3", 32'(ready_s[1]), 32'h1);

        foreach (vec[i]) begin
            access(0, vec[i].w, vec[i].f3, vec[i].a, vec[i].wd, rd, flt, lat);
            check({vec[i].name, "_rdata"}, rd, vec[i].er);
            check({vec[i].name, "_fault"}, 32'(flt), 32'(vec[i].ef));
            check({vec[i].name, "_lat"}, 32'(lat), 32'd1);
        end
        @(negedge clk);
        check("idle_resp",  32'(resp_s[0]),  32'h0);
        check("idle_rdata", rdata_s[0],      32'h0);

        // Back-to-back with req held high, alternating SW/LW to one address.
        prev = -1;
        req_s[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!ready_s[0] && n < 10) begin
                @(negedge clk);
                n++;
            end
            acc = cyc;
            we_s[0] = (i % 2 == 0); f3_s[0] = 3'b010; addr_s[0] = 32'h30;
            wdata_s[0] = 32'hC0DE0000 + 32'(i);
            if (i > 0) check("b2b_interval", 32'(acc - prev), 32'd2);
            prev = acc;
            @(posedge clk);
            @(negedge clk);
            check("b2b_resp", 32'(resp_s[0]), 32'h1);
            if (i % 2 == 1) check("b2b_lw", rdata_s[0], 32'hC0DE0000 + 32'(i - 1));
        end
        req_s[0] = 1'b0;

        // Wait-state instance: plain latency, then req held through WAIT.
        access(1, 1'b0, 3'b010, 32'h08, 32'h0, rd, flt, lat);
        check("ws_lw08", rd, 32'h2);
        check("ws_lat", 32'(lat), 32'd4);
        @(negedge clk);
        req_s[1] = 1'b1; we_s[1] = 1'b0; f3_s[1] = 3'b010; addr_s[1] = 32'h0C;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("hold_ready_%0d", k), 32'(ready_s[1]), 32'(k >= 5));
            check($sformatf("hold_resp_%0d", k),  32'(resp_s[1]),  32'(k == 4));
            if (k == 4) begin
                check("hold_rdata", rdata_s[1], 32'h3);
                req_s[1] = 1'b0;
            end
        end

        // Reset during WAIT aborts the store and re-initialises memory.
        req_s[1] = 1'b1; we_s[1] = 1'b1; f3_s[1] = 3'b010; addr_s[1] = 32'h08;
        wdata_s[1] = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_s[1] = 1'b0;
        rst_s[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_resp", 32'(resp_s[1]), 32'h0);
        end
        rst_s[1] = 1'b0;
        count_init(1, n);
        check("reinit_cycles", 32'(n), 32'd64);
        access(1, 1'b0, 3'b010, 32'h08, 32'h0, rd, flt, lat);
        check("reinit_lw08", rd, 32'h2);
        check("reinit_fault", 32'(flt), 32'h0);
        check("reinit_lat", 32'(lat), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_lsu_mem.md
# dmem_lsu_mem

Parametrised data memory for the RISC-V core's MEM stage. It replaces the flat word-only store with byte, halfword and word loads and stores selected by funct3, sign and zero extension, and fault detection for misaligned, out-of-range and illegal accesses. Accesses use a req/ready request and a one-cycle resp_valid response with a configurable number of wait states. After reset, an init sequencer writes its own word index into every word, one word per cycle, before the first request is accepted.

## Interface
- DEPTH, 64: number of 32-bit words (≥2, need not be a power of two)
- ADDR_W, 32: byte-address width
- WAIT_STATES, 0: extra response cycles, 0..15
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- req  in  1  request strobe
- we  in  1  1 = store, 0 = load; sampled with req
- funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; all other codes illegal
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, taken from the low-order bytes
- ready  out  1  high only in IDLE; the request is accepted on an edge where req && ready
- resp_valid  out  1  one-cycle response pulse
- rdata  out  32  load result; 0 unless resp_valid is high and the access is a non-faulting load
- fault  out  1  valid only with resp_valid

## Operation
- The FSM has four states: INIT, IDLE, WAIT, RESP.
- Reset forces INIT and clears the init counter, the wait counter, and all response registers.
  - Reset values of outputs: ready=0, resp_valid=0, rdata=0, fault=0.
- INIT: each cycle, mem[idx] ← idx (zero-extended to 32 bits), then idx increments.
  - When idx=DEPTH−1 has been written, the FSM moves to IDLE.
  - INIT therefore lasts exactly DEPTH cycles after reset deasserts.
- IDLE: ready=1. Acceptance moves the FSM to WAIT if WAIT_STATES>0, otherwise to RESP.
- WAIT: the counter runs WAIT_STATES cycles, then the FSM moves to RESP.
- RESP: resp_valid=1 for one cycle, then the FSM returns to IDLE.
- Word index = addr[ADDR_W−1:2]. Byte lanes are little-endian; lane = addr[1:0].
- A request faults if any of the following holds:
  - the funct3 code is illegal;
  - the word index is ≥ DEPTH;
  - a halfword access has addr[0]=1;
  - a word access has addr[1:0]≠0;
  - the store codes 100 or 101 are used (LBU/LHU codes with we=1 are illegal).
- A faulting access writes nothing, returns rdata=0 and fault=1, and uses the same latency as a good access.
- Stores commit on the accepting edge:
  - SB writes wdata[7:0] into lane addr[1:0];
  - SH writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1};
  - SW writes the full word.
  - Other lanes are unchanged. A store response carries rdata=0 and fault=0.
- Loads read the word on the accepting edge and hold the extracted result until RESP:
  - LB/LBU sign- or zero-extend the addressed byte;
  - LH/LHU sign- or zero-extend the halfword at addr[1];
  - LW returns the full word.
- req, we, funct3, addr and wdata are ignored outside IDLE.
- Reset mid-operation (INIT, WAIT or RESP) aborts the access: no resp_valid is produced, memory is re-initialised, and stores already committed are overwritten by the init sequence.

## Timing
- Request accepted at the edge ending cycle T → resp_valid is high in cycle T+1+WAIT_STATES only.
- ready is low from T+1 through the RESP cycle and returns high in T+2+WAIT_STATES.
  - Maximum throughput is one access per WAIT_STATES+2 cycles.
- A load in the cycle after a store's RESP observes the stored data.
- rdata and fault are registered; no input-to-output combinational path exists.

## Test plan
- Init and first load (DEPTH=64, WAIT_STATES=0): reset high 1 cycle, then low → ready stays 0 for 64 cycles, then goes 1. LW at 0x3C → resp_valid one cycle after acceptance, rdata=0x0000000F, fault=0.
- Sub-word stores and loads:
  - SW 0x11223344 @0x10, then LB 0x11 → 0x00000033; LBU 0x13 → 0x00000011; LH 0x12 → 0x00001122.
  - SB 0x80 @0x14, then LB 0x14 → 0xFFFFFF80; LBU 0x14 → 0x00000080; LW 0x14 → 0x00000080.
- Faults: each of the following gives fault=1, rdata=0, and no write:
  - SH @0x21, then LW 0x20 still returns 0x00000008;
  - LW @0x102;
  - LW @0x100 (index 64);
  - funct3=011;
  - we=1 with funct3=100.
- Latency (WAIT_STATES=3): accept at T → resp_valid only in T+4. ready is 0 in T+1..T+4 and returns to 1 in T+5. A req held high during WAIT is not accepted and causes no extra response.
- Reset mid-access (WAIT_STATES=3): SW 0xDEADBEEF @0x08, reset asserted in WAIT → no resp_valid. After re-init, LW 0x08 returns 0x00000002.
- Back-to-back (WAIT_STATES=0): req held high with alternating SW/LW to the same address → one acceptance every 2 cycles, and each LW returns the preceding SW's data.
